audio_frame_sched: RTL and testbench
====================================

# audio_frame_sched

Frame scheduler between the audio input FIFO bank and its downstream DSP consumers. It presents the current multichannel frame to up to NUM_CONSUMERS consumers and collects one acknowledge from each enabled consumer. Only then does it advance the FIFO read pointer, using the FIFO's level-to-pulse `adv_read_req` handshake. It also enforces a per-frame timeout and counts FIFO overflow episodes.

## Interface
- NUM_CONSUMERS, 4, number of consumer ports (1..16)
- TIMEOUT_CYCLES, 1024, max sys_clk cycles a frame waits in PRESENT or ADVANCE before forced completion (≥2)
- OVF_CNT_WIDTH, 16, width of the saturating overflow counter

Ports:
- sys_clk  in  1  system clock; the single clock of the block
- sys_rst_n  in  1  asynchronous, active-low reset
- buf_ready  in  1  FIFO holds ≥1 sample in every mono channel
- buf_full  in  1  any FIFO channel full
- buf_adv_read_enable  in  1  FIFO's one-cycle advance pulse (edge of buf_adv_read_req)
- buf_adv_read_req  out  1  advance request level to FIFO
- cons_enable  in  NUM_CONSUMERS  per-consumer participation mask
- cons_ack  in  NUM_CONSUMERS  per-consumer "frame consumed" pulse/level
- frame_valid  out  1  FIFO audio outputs hold a frame consumers may sample
- cons_pending  out  NUM_CONSUMERS  consumers still owing an ack for the current frame
- timeout_evt  out  1  one-cycle pulse on forced frame completion
- timeout_drop_mask  out  NUM_CONSUMERS  pending mask captured at the last timeout
- ovf_count  out  OVF_CNT_WIDTH  saturating count of buf_full rising edges
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, PRESENT, ADVANCE, SETTLE. The state is registered, and all outputs are registered or decoded from state/pending.
- IDLE to PRESENT: requires buf_ready=1 and cons_enable≠0. On entry, pending←cons_enable and tmo_cnt←0.
- IDLE with cons_enable=0: the block stays in IDLE and never advances. The FIFO's own overflow-drop handles backlog.
- PRESENT, frame_valid=1: each cycle pending←pending & ~cons_ack & cons_enable.
  - An ack from a non-pending or disabled consumer is ignored.
  - Disabling a consumer mid-frame removes it from pending.
- PRESENT to ADVANCE: taken when (pending & ~cons_ack & cons_enable)=0, evaluated combinationally on the current cycle.
- PRESENT timeout: when tmo_cnt reaches TIMEOUT_CYCLES-1, the block pulses timeout_evt, sets timeout_drop_mask←pending, clears pending and moves to ADVANCE.
- ADVANCE: buf_adv_read_req=1 and frame_valid=0. The block holds until buf_adv_read_enable=1 is sampled, then moves to SETTLE.
- ADVANCE timeout: if TIMEOUT_CYCLES elapse with no enable, the block pulses timeout_evt with timeout_drop_mask←0 and moves to SETTLE (lost handshake).
- SETTLE: buf_adv_read_req=0 for exactly one cycle, which guarantees a fresh rising edge for the next advance. The block then returns to IDLE.
- tmo_cnt: clears on every state change and saturates at TIMEOUT_CYCLES-1.
- Overflow counter: a registered buf_full delay detects rising edges. ovf_count increments by 1 per edge and saturates at all-ones. It never wraps and runs independently of the FSM.

## Timing
- Reset values: buf_adv_read_req=0, frame_valid=0, cons_pending=0, timeout_evt=0, timeout_drop_mask=0, ovf_count=0, busy=0, state=IDLE.
- Reset assertion mid-frame forces all of the above immediately (asynchronous). Deassertion is synchronised externally.
- Frame latency: buf_ready high at cycle t gives PRESENT/frame_valid at t+1.
- Ack latency: acks completing pending at cycle p give ADVANCE (req=1) at p+1.
- Advance handshake: enable seen at cycle a gives SETTLE at a+1 and IDLE at a+2.
- Minimum frame period: 4 cycles (IDLE, PRESENT, ADVANCE, SETTLE) when acks and enable are same-cycle.
- buf_adv_read_req is glitch-free and low for ≥1 cycle between any two high periods.
- frame_valid is never high in the cycle after the FIFO read pointer moves.
- Simultaneous timeout and final ack in PRESENT: the ack wins, so there is no timeout_evt and timeout_drop_mask is unchanged.

## Structure
- Package audio_sched_pkg holds:
  - typedef enum logic [1:0] sched_state_t {IDLE, PRESENT, ADVANCE, SETTLE}
  - localparams for the default TIMEOUT_CYCLES and tmo_cnt width ($clog2(TIMEOUT_CYCLES)).
- Sub-module sat_counter (parameter WIDTH; inputs inc and clr; saturating output) is used for ovf_count. tmo_cnt stays inline.
- Rising-edge detection of buf_full reuses the common pos_edge_det.

## Test plan
- Basic frame, NUM_CONSUMERS=4, cons_enable=4'b1111:
  - Stimulus: buf_ready=1; acks on consumers 0–3 at cycles 2, 3, 3, 5 after PRESENT.
  - Required: cons_pending goes 1111→1110→1000→0000, then req high for one enable, SETTLE, IDLE, with exactly one enable pulse.
- Same-cycle fast path:
  - Stimulus: all acks in the first PRESENT cycle; buf_adv_read_enable combinational from req.
  - Required: back-to-back frames every 4 cycles while buf_ready=1.
- Consumer timeout, TIMEOUT_CYCLES=8:
  - Stimulus: consumer 2 never acks.
  - Required: timeout_evt at PRESENT cycle 8, timeout_drop_mask=4'b0100, advance still occurs.
- Mid-frame disable:
  - Stimulus: cons_enable 1111→1011 while consumer 2 is pending.
  - Required: pending[2] clears next cycle, no timeout_evt.
- Overflow count:
  - Stimulus: 3 buf_full pulses, then OVF_CNT_WIDTH=2 with 5 pulses.
  - Required: ovf_count=3, then saturation at 3.
- Async reset in ADVANCE:
  - Stimulus: assert sys_rst_n=0 with req=1.
  - Required: req, frame_valid, pending, busy are 0 in the same cycle; after release the block waits in IDLE for buf_ready.

Source files
------------

// File: rtl/audio_sched_pkg.sv
// Shared types and defaults for the audio frame scheduler.
package audio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        ADVANCE,
        SETTLE
    } sched_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 1024;

    function automatic int tmo_w(input int cycles);
        return $clog2(cycles);
    endfunction

    localparam int TMO_CNT_W_DEF = tmo_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/pos_edge_det.sv
// Rising-edge detector: one-cycle pulse when d goes 0 -> 1.
module pos_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;
    logic d_d;

    always_comb d_d = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/audio_frame_sched.sv
// Presents FIFO frames to DSP consumers, collects acks, then
// advances the FIFO read pointer with a per-frame timeout.
module audio_frame_sched
    import audio_sched_pkg::*;
#(
    parameter int NUM_CONSUMERS  = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int OVF_CNT_WIDTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     buf_ready,
    input  logic                     buf_full,
    input  logic                     buf_adv_read_enable,
    output logic                     buf_adv_read_req,
    input  logic [NUM_CONSUMERS-1:0] cons_enable,
    input  logic [NUM_CONSUMERS-1:0] cons_ack,
    output logic                     frame_valid,
    output logic [NUM_CONSUMERS-1:0] cons_pending,
    output logic                     timeout_evt,
    output logic [NUM_CONSUMERS-1:0] timeout_drop_mask,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count,
    output logic                     busy
);

    localparam int TW = tmo_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t             state_q, state_d;
    logic [NUM_CONSUMERS-1:0] pending_q, pending_d;
    logic [NUM_CONSUMERS-1:0] drop_q, drop_d;
    logic [NUM_CONSUMERS-1:0] pend_nxt;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     tmo_hit;
    logic                     evt_q, evt_d;
    logic                     req_q, req_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     full_rise;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        evt_d     = 1'b0;
        pend_nxt  = pending_q & ~cons_ack & cons_enable;
        tmo_hit   = (tmo_q == TMO_LAST);
        tmo_d     = tmo_hit ? tmo_q : tmo_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (buf_ready && (cons_enable != '0)) begin
                    state_d   = PRESENT;
                    pending_d = cons_enable;
                end
            end
            PRESENT: begin
                // Final ack beats a coincident timeout.
                if (pend_nxt == '0) begin
                    state_d   = ADVANCE;
                    pending_d = '0;
                end else if (tmo_hit) begin
                    state_d   = ADVANCE;
                    evt_d     = 1'b1;
                    drop_d    = pending_q;
                    pending_d = '0;
                end else begin
                    pending_d = pend_nxt;
                end
            end
            ADVANCE: begin
                if (buf_adv_read_enable) begin
                    state_d = SETTLE;
                end else if (tmo_hit) begin
                    state_d = SETTLE;
                    evt_d   = 1'b1;
                    drop_d  = '0;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            tmo_d = '0;

        req_d   = (state_d == ADVANCE);
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            drop_q    <= '0;
            tmo_q     <= '0;
            evt_q     <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            evt_q     <= evt_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    pos_edge_det u_full_edge (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (buf_full),
        .pulse (full_rise)
    );

    sat_counter #(.WIDTH(OVF_CNT_WIDTH)) u_ovf_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (full_rise),
        .clr   (1'b0),
        .count (ovf_count)
    );

    assign buf_adv_read_req  = req_q;
    assign frame_valid       = valid_q;
    assign cons_pending      = pending_q;
    assign timeout_evt       = evt_q;
    assign timeout_drop_mask = drop_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_audio_frame_sched.sv
// Directed self-checking bench for audio_frame_sched.
module tb_audio_frame_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       buf_ready;
    logic       buf_full;
    logic       en_man;
    logic       fast;
    logic       buf_adv_read_enable;
    logic [3:0] cons_enable;
    logic [3:0] cons_ack;

    logic        req, valid, evt, busy;
    logic [3:0]  pending, drop;
    logic [15:0] ovf;

    logic       n_req, n_valid, n_evt, n_busy;
    logic [3:0] n_pending, n_drop;
    logic [1:0] n_ovf;

    int passed = 0;
    int total  = 0;

    always #5 sys_clk = ~sys_clk;

    assign buf_adv_read_enable = fast ? req : en_man;

    audio_frame_sched #(
        .NUM_CONSUMERS(4), .TIMEOUT_CYCLES(8), .OVF_CNT_WIDTH(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .buf_ready(buf_ready), .buf_full(buf_full),
        .buf_adv_read_enable(buf_adv_read_enable),
        .buf_adv_read_req(req),
        .cons_enable(cons_enable), .cons_ack(cons_ack),
        .frame_valid(valid), .cons_pending(pending),
        .timeout_evt(evt), .timeout_drop_mask(drop),
        .ovf_count(ovf), .busy(busy)
    );

    audio_frame_sched #(
        .NUM_CONSUMERS(4), .TIMEOUT_CYCLES(8), .OVF_CNT_WIDTH(2)
    ) dut_narrow (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .buf_ready(buf_ready), .buf_full(buf_full),
        .buf_adv_read_enable(buf_adv_read_enable),
        .buf_adv_read_req(n_req),
        .cons_enable(cons_enable), .cons_ack(cons_ack),
        .frame_valid(n_valid), .cons_pending(n_pending),
        .timeout_evt(n_evt), .timeout_drop_mask(n_drop),
        .ovf_count(n_ovf), .busy(n_busy)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        buf_ready   = 1'b0;
        buf_full    = 1'b0;
        en_man      = 1'b0;
        fast        = 1'b0;
        cons_enable = 4'b1111;
        cons_ack    = 4'b0000;
        tick();
        tick();
        chk("rst_req", 32'(req), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_evt", 32'(evt), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        sys_rst_n = 1'b1;
        tick();
        chk("idle_no_ready", 32'(busy), 0);

        // Basic frame with staggered acks
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        chk("bas_valid", 32'(valid), 1);
        chk("bas_pend0", 32'(pending), 4'b1111);
        tick();
        cons_ack = 4'b0001;
        tick();
        chk("bas_pend1", 32'(pending), 4'b1110);
        cons_ack = 4'b0110;
        tick();
        chk("bas_pend2", 32'(pending), 4'b1000);
        cons_ack = 4'b0000;
        tick();
        chk("bas_pend3", 32'(pending), 4'b1000);
        cons_ack = 4'b1000;
        tick();
        cons_ack = 4'b0000;
        chk("bas_pend4", 32'(pending), 4'b0000);
        chk("bas_req", 32'(req), 1);
        chk("bas_valid_adv", 32'(valid), 0);
        tick();
        tick();
        chk("bas_req_hold", 32'(req), 1);
        en_man = 1'b1;
        tick();
        en_man = 1'b0;
        chk("bas_settle_req", 32'(req), 0);
        chk("bas_settle_busy", 32'(busy), 1);
        chk("bas_settle_valid", 32'(valid), 0);
        tick();
        chk("bas_idle_busy", 32'(busy), 0);
        tick();
        chk("bas_idle_stay", 32'(busy), 0);

        // Same-cycle fast path: 4-cycle frame period
        fast      = 1'b1;
        cons_ack  = 4'b1111;
        buf_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("fast_valid_%0d", k), 32'(valid),
                32'((k % 4) == 1));
            chk($sformatf("fast_req_%0d", k), 32'(req),
                32'((k % 4) == 2));
        end
        buf_ready = 1'b0;
        fast      = 1'b0;
        cons_ack  = 4'b0000;
        tick();
        chk("fast_idle", 32'(busy), 0);

        // Consumer 2 never acks: PRESENT timeout
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        cons_ack  = 4'b1011;
        tick();
        cons_ack  = 4'b0000;
        chk("tmo_pend", 32'(pending), 4'b0100);
        for (int i = 2; i <= 7; i++) begin
            tick();
            chk($sformatf("tmo_wait_evt_%0d", i), 32'(evt), 0);
            chk($sformatf("tmo_wait_valid_%0d", i), 32'(valid), 1);
        end
        tick();
        chk("tmo_evt", 32'(evt), 1);
        chk("tmo_drop", 32'(drop), 4'b0100);
        chk("tmo_req", 32'(req), 1);
        chk("tmo_pend_clr", 32'(pending), 0);
        tick();
        chk("tmo_evt_pulse", 32'(evt), 0);
        en_man = 1'b1;
        tick();
        en_man = 1'b0;
        tick();
        chk("tmo_idle", 32'(busy), 0);
        chk("tmo_drop_keep", 32'(drop), 4'b0100);

        // Mid-frame disable of the only pending consumer
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        cons_ack  = 4'b1011;
        tick();
        cons_ack    = 4'b0000;
        cons_enable = 4'b1011;
        tick();
        chk("dis_pend", 32'(pending), 0);
        chk("dis_req", 32'(req), 1);
        chk("dis_evt", 32'(evt), 0);
        cons_enable = 4'b1111;
        en_man = 1'b1;
        tick();
        en_man = 1'b0;
        chk("dis_evt2", 32'(evt), 0);
        tick();

        // Final ack coincides with the timeout cycle
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        cons_ack  = 4'b0111;
        tick();
        cons_ack  = 4'b0000;
        chk("race_pend", 32'(pending), 4'b1000);
        for (int i = 2; i <= 7; i++) tick();
        chk("race_still_valid", 32'(valid), 1);
        cons_ack = 4'b1000;
        tick();
        cons_ack = 4'b0000;
        chk("race_req", 32'(req), 1);
        chk("race_evt", 32'(evt), 0);
        chk("race_drop", 32'(drop), 4'b0100);

        // Lost advance handshake: ADVANCE timeout
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("advtmo_req_%0d", i), 32'(req), 1);
        end
        tick();
        chk("advtmo_evt", 32'(evt), 1);
        chk("advtmo_drop", 32'(drop), 0);
        chk("advtmo_req", 32'(req), 0);
        chk("advtmo_busy", 32'(busy), 1);
        tick();
        chk("advtmo_idle", 32'(busy), 0);
        chk("advtmo_evt_pulse", 32'(evt), 0);

        // Overflow episodes: wide and 2-bit counters
        for (int i = 1; i <= 8; i++) begin
            buf_full = 1'b1;
            tick();
            if (i == 8) tick();
            buf_full = 1'b0;
            tick();
            chk($sformatf("ovf_wide_%0d", i), 32'(ovf), i);
            chk($sformatf("ovf_narrow_%0d", i), 32'(n_ovf),
                (i > 3) ? 3 : i);
        end

        // Async reset while in ADVANCE
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        cons_ack  = 4'b1111;
        tick();
        cons_ack  = 4'b0000;
        chk("ar_req_pre", 32'(req), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(req), 0);
        chk("ar_valid", 32'(valid), 0);
        chk("ar_pending", 32'(pending), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ovf", 32'(ovf), 0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk("ar_wait_busy", 32'(busy), 0);
        chk("ar_wait_valid", 32'(valid), 0);
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        chk("ar_restart_valid", 32'(valid), 1);
        chk("ar_restart_pend", 32'(pending), 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
